// File: rtl/mod_i2s_tx.sv
// I2S transmitter: scales/saturates signed samples into a FIFO of slot words and
// serialises each as a stereo frame with internally generated BCLK/LRCLK.
module mod_i2s_tx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int BCLK_DIV    = 4,
  parameter int SAMPLE_BITS = 24,
  parameter int SHIFT       = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [31:0]                   i_sound,
  input  logic                          i_valid,
  input  logic                          i_enable,
  input  logic                          i_clear_flags,
  output logic                          o_bclk,
  output logic                          o_lrclk,
  output logic                          o_sdata,
  output logic                          o_tick,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill,
  output logic                          o_overflow,
  output logic                          o_underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (SAMPLE_BITS - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = ~SAT_MAX;

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic [31:0]   frame_q, frame_d;
  logic          tick_q, tick_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic signed [31:0] shifted_w, sat_w;
  logic [31:0]        slot_w;
  logic [5:0]         cnt_nx;
  logic               term, fall, pop_ev, empty, full, do_pop, do_push;

  always_comb begin
    shifted_w = $signed(i_sound) >>> SHIFT;
    if (shifted_w > SAT_MAX)      sat_w = SAT_MAX;
    else if (shifted_w < SAT_MIN) sat_w = SAT_MIN;
    else                          sat_w = shifted_w;
    slot_w = 32'(sat_w) << (32 - SAMPLE_BITS);
  end

  assign term    = (div_q == DIV_LAST);
  assign fall    = i_enable && term && bclk_q;
  assign cnt_nx  = cnt_q + 6'd1;
  assign pop_ev  = fall && (cnt_q == 6'd62);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = pop_ev && !empty;
  // A pop in the same cycle frees the slot the push would otherwise be denied.
  assign do_push = i_enable && i_valid && (!full || do_pop);

  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    cnt_d   = cnt_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    frame_d = frame_q;
    tick_d  = 1'b0;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = (ovf_q && !i_clear_flags) || (i_enable && i_valid && full && !do_pop);
    unf_d   = (unf_q && !i_clear_flags) || (pop_ev && empty);
    if (!i_enable) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      cnt_d   = '1;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      frame_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      div_d  = term ? '0 : div_q + DW'(1);
      bclk_d = term ? ~bclk_q : bclk_q;
      if (fall) begin
        cnt_d   = cnt_nx;
        sdata_d = frame_q[~cnt_nx[4:0]];
        lrclk_d = (cnt_nx >= 6'd31) && (cnt_nx <= 6'd62);
      end
      if (pop_ev) begin
        frame_d = empty ? '0 : mem_q[rd_q];
        tick_d  = 1'b1;
      end
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push) wr_d = wr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      cnt_q   <= '1;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      frame_q <= '0;
      tick_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      cnt_q   <= cnt_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= slot_w;
  end

  assign o_bclk      = bclk_q;
  assign o_lrclk     = lrclk_q;
  assign o_sdata     = sdata_q;
  assign o_tick      = tick_q;
  assign o_fill      = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_mod_i2s_tx.sv
// Bench for mod_i2s_tx: directed pushes with expected frame words queued; an I2S
// receiver process decodes o_sdata/o_lrclk and checks each frame against the queue.
module tb_mod_i2s_tx;

  logic        clk, rst_n, valid, enable, clear;
  logic [31:0] sound;
  logic        bclk, lrclk, sdata, tick, ovf, unf;
  logic [2:0]  fill;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  mod_i2s_tx #(.FIFO_DEPTH(4), .BCLK_DIV(2), .SAMPLE_BITS(24), .SHIFT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sound(sound), .i_valid(valid),
    .i_enable(enable), .i_clear_flags(clear), .o_bclk(bclk), .o_lrclk(lrclk),
    .o_sdata(sdata), .o_tick(tick), .o_fill(fill), .o_overflow(ovf),
    .o_underflow(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    valid = 1'b1;
    sound = v;
    step();
    valid = 1'b0;
  endtask

  task automatic wait_tick(input string name, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (tick !== 1'b1 && n < 400);
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s got no_tick expected tick within 400 cycles", name);
    end
  endtask

  task automatic bclk_period(output int p);
    int n;
    n = 0;
    while (bclk !== 1'b0 && n < 20) begin step(); n++; end
    while (bclk !== 1'b1 && n < 20) begin step(); n++; end
    p = 0;
    while (bclk === 1'b1 && p < 20) begin step(); p++; end
    while (bclk === 1'b0 && p < 20) begin step(); p++; end
  endtask

  // I2S receiver: a word is complete on the bit where LRCLK changes.
  logic        prev_b, prev_lr;
  logic [31:0] sh, left;
  always @(negedge clk) begin
    if (!rst_n || !enable) begin
      prev_b  = 1'b0;
      prev_lr = 1'b0;
      sh      = '0;
      left    = '0;
    end else begin
      if (bclk && !prev_b) begin
        sh = {sh[30:0], sdata};
        if (lrclk != prev_lr) begin
          if (!prev_lr) left = sh;
          else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected got %h expected none", sh);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("frame_left", {32'd0, left}, {32'd0, e});
            check("frame_right", {32'd0, sh}, {32'd0, e});
          end
        end
        prev_lr = lrclk;
      end
      prev_b = bclk;
    end
  end

  int n, p;

  initial begin
    rst_n = 1'b0; enable = 1'b1; valid = 1'b0; clear = 1'b0; sound = '0;
    repeat (3) step();
    check("reset_outputs", {bclk, lrclk, sdata, tick, ovf, unf, fill}, '0);

    // basic frame: frame 0 zeros, frame 1 carries the first sample
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h1234_5600);
    exp_q.push_back(32'h7FFF_FF00);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'hEDCB_A900);
    exp_q.push_back(32'h0000_0000);
    rst_n = 1'b1;
    push(32'h0123_4560);
    check("fill_after_push", fill, 1);
    wait_tick("tick1", n);
    check("first_tick_latency", n + 1, 256);
    check("fill_after_pop", fill, 0);
    check("no_underflow_first_pop", unf, 0);
    step();
    check("tick_one_cycle", tick, 0);
    bclk_period(p);
    check("bclk_period", p, 4);

    // saturation and negative in-range sample
    push(32'h7FFF_FFF0);
    push(32'h8000_0000);
    push(32'hFEDC_BA90);
    check("fill_three", fill, 3);
    wait_tick("tick2", n);
    wait_tick("tick3", n);
    check("tick_period", n, 256);
    check("fill_after_tick3", fill, 1);
    wait_tick("tick4", n);
    check("underflow_not_yet", unf, 0);
    wait_tick("tick5", n);
    check("underflow_set", unf, 1);

    // overflow: five back-to-back pushes, fifth lost
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'hFFFF_FF00);
    exp_q.push_back(32'h0555_5500);
    exp_q.push_back(32'hFAAA_AA00);
    exp_q.push_back(32'h0333_3300);
    exp_q.push_back(32'h7FFF_FF00);
    push(32'h0000_0010);
    push(32'hFFFF_FFF0);
    push(32'h0055_5550);
    push(32'hFFAA_AAA0);
    push(32'h0111_1110);
    check("overflow_fill", fill, 4);
    check("overflow_set", ovf, 1);
    wait_tick("tick6", n);
    check("fill_after_tick6", fill, 3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_flags", {ovf, unf}, 2'b00);
    push(32'h0033_3330);
    check("refill", fill, 4);
    repeat (253) step();
    push(32'h07FF_FFF0);   // lands on the pop edge
    check("push_on_pop_tick", tick, 1);
    check("push_on_pop_fill", fill, 4);
    check("push_on_pop_no_ovf", ovf, 0);

    // full again, then disable at cnt=10
    push(32'h0000_0000);
    check("overflow_again", ovf, 1);
    repeat (43) step();
    check("sdata_cnt10", {lrclk, sdata}, 2'b01);
    enable = 1'b0;
    step();
    exp_q.delete();
    check("disable_outputs", {bclk, lrclk, sdata, tick, fill}, '0);
    check("disable_flags_hold", {ovf, unf}, 2'b10);
    push(32'h1234_0000);
    check("disabled_push_ignored", {fill, ovf}, {3'd0, 1'b1});

    // re-enable: FIFO was flushed, so two zero frames
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0000);
    enable = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_after_enable", {ovf, unf}, 2'b00);
    wait_tick("reenable_tick", n);
    check("reenable_tick_latency", n, 255);
    check("underflow_after_flush", unf, 1);

    // async reset at cnt=40 between edges
    push(32'h00AB_CDE0);
    repeat (163) step();
    check("lrclk_cnt40", lrclk, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bclk, lrclk, sdata, tick, ovf, unf, fill}, '0);
    exp_q.delete();
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0ABC_DE00);
    repeat (2) step();
    rst_n = 1'b1;
    push(32'h00AB_CDE0);
    wait_tick("post_reset_tick", n);
    check("post_reset_tick_latency", n + 1, 256);
    wait_tick("post_reset_tick2", n);
    repeat (10) step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
